// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick control mapper with coin/start sequencer
// Optional auto-fire is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
  parameter int NUM_PLAYERS       = 2,
  parameter int COIN_PULSE_CYCLES = 600000,
  parameter int AUTOFIRE_DIV      = 60000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joy_flat,
  output logic [4*NUM_PLAYERS-1:0]  dir_n,
  output logic [NUM_PLAYERS-1:0]    fire_n,
  output logic [NUM_PLAYERS-1:0]    start_n,
  output logic                      coin_n,
  output logic                      test_n
);

  localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE_CYCLES - 1);
  localparam logic [23:0] AF_LAST    = 24'(AUTOFIRE_DIV - 1);

  typedef enum logic [1:0] {IDLE, COIN, GAP, START} state_t;

  logic       prev_toggle;
  logic       kb_u, kb_d, kb_l, kb_r, kb_fire_a, kb_fire_b, kb_coin, kb_test;
  logic [3:0] kb_start;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev_toggle <= ps2_key[10];
      kb_u        <= 1'b0;
      kb_d        <= 1'b0;
      kb_l        <= 1'b0;
      kb_r        <= 1'b0;
      kb_fire_a   <= 1'b0;
      kb_fire_b   <= 1'b0;
      kb_coin     <= 1'b0;
      kb_test     <= 1'b0;
      kb_start    <= '0;
    end else begin
      prev_toggle <= ps2_key[10];
      if (ps2_key[10] != prev_toggle) begin
        case (ps2_key[7:0])
          8'h75:   kb_u        <= ps2_key[9];
          8'h72:   kb_d        <= ps2_key[9];
          8'h6B:   kb_l        <= ps2_key[9];
          8'h74:   kb_r        <= ps2_key[9];
          8'h29:   kb_fire_a   <= ps2_key[9];
          8'h14:   kb_fire_b   <= ps2_key[9];
          8'h05:   kb_start[0] <= ps2_key[9];
          8'h06:   kb_start[1] <= ps2_key[9];
          8'h07:   kb_start[2] <= ps2_key[9];
          8'h08:   kb_start[3] <= ps2_key[9];
          8'h2E:   kb_coin     <= ps2_key[9];
          8'h0C:   kb_test     <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  logic [4*NUM_PLAYERS-1:0] dir_act;
  logic [NUM_PLAYERS-1:0]   fire_act;
  logic [NUM_PLAYERS-1:0]   start_req;
  logic                     coin_req;
  logic [15:0]              pj;
  logic [3:0]               dtmp;

  // Keyboard only ever drives player 0; start/coin requests are shared by everyone.
  always_comb begin
    dir_act   = '0;
    fire_act  = '0;
    start_req = kb_start[NUM_PLAYERS-1:0];
    coin_req  = kb_coin;
    pj        = '0;
    dtmp      = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      pj   = joy_flat[16*p +: 16];
      dtmp = pj[3:0];
      if (p == 0) dtmp = dtmp | {kb_u, kb_d, kb_l, kb_r};
      if (dtmp[0] && dtmp[1]) dtmp[1:0] = 2'b00;
      if (dtmp[2] && dtmp[3]) dtmp[3:2] = 2'b00;
      dir_act[4*p +: 4] = dtmp;
      fire_act[p] = pj[4] | ((p == 0) & (kb_fire_a | kb_fire_b));
      coin_req = coin_req | pj[9];
      for (int k = 0; k < NUM_PLAYERS; k++) start_req[k] = start_req[k] | pj[5+k];
    end
  end

  logic [NUM_PLAYERS-1:0] af_fire;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [23:0]            af_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] af_phase;

  always_ff @(posedge clk_sys) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (reset || !joy_flat[16*p+10]) begin
        af_cnt[p]   <= '0;
        af_phase[p] <= 1'b0;
      end else if (af_cnt[p] == AF_LAST) begin
        af_cnt[p]   <= '0;
        af_phase[p] <= ~af_phase[p];
      end else begin
        af_cnt[p]   <= af_cnt[p] + 24'd1;
      end
    end
  end

  always_comb begin
    af_fire = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) af_fire[p] = joy_flat[16*p+10] & ~af_phase[p];
  end
`else
  assign af_fire = '0;
`endif

  state_t                 state, state_d;
  logic [23:0]            cnt, cnt_d;
  logic [1:0]             pidx, pidx_d;
  logic                   pvalid, pvalid_d;
  logic [NUM_PLAYERS-1:0] prev_start_req, start_rise;
  logic                   prev_coin_req, coin_rise;
  logic [1:0]             first_k;
  logic [NUM_PLAYERS-1:0] start_drive;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      pidx           <= '0;
      pvalid         <= 1'b0;
      prev_start_req <= '0;
      prev_coin_req  <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      pidx           <= pidx_d;
      pvalid         <= pvalid_d;
      prev_start_req <= start_req;
      prev_coin_req  <= coin_req;
    end
  end

  // Request edges are tracked in every state so a request held across a sequence never retriggers.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    pidx_d     = pidx;
    pvalid_d   = pvalid;
    start_rise = start_req & ~prev_start_req;
    coin_rise  = coin_req & ~prev_coin_req;
    first_k    = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) if (start_rise[k]) first_k = 2'(k);
    case (state)
      IDLE: begin
        if (|start_rise) begin
          state_d  = COIN;
          cnt_d    = PULSE_LOAD;
          pidx_d   = first_k;
          pvalid_d = 1'b1;
        end else if (coin_rise) begin
          state_d  = COIN;
          cnt_d    = PULSE_LOAD;
          pvalid_d = 1'b0;
        end
      end
      COIN: begin
        if (cnt == '0) begin
          state_d = GAP;
          cnt_d   = PULSE_LOAD;
        end else cnt_d = cnt - 24'd1;
      end
      GAP: begin
        if (cnt == '0) begin
          state_d = pvalid ? START : IDLE;
          cnt_d   = PULSE_LOAD;
        end else cnt_d = cnt - 24'd1;
      end
      START: begin
        if (cnt == '0) state_d = IDLE;
        else cnt_d = cnt - 24'd1;
      end
      default: state_d = IDLE;
    endcase
    start_drive = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) start_drive[k] = (state_d == START) && (pidx_d == 2'(k));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir_n   <= '1;
      fire_n  <= '1;
      start_n <= '1;
      coin_n  <= 1'b1;
      test_n  <= 1'b1;
    end else begin
      dir_n   <= ~dir_act;
      fire_n  <= ~(fire_act | af_fire);
      start_n <= ~start_drive;
      coin_n  <= (state_d != COIN);
      test_n  <= ~kb_test;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_flat, kb_start, AF_LAST};

endmodule
